// File: rtl/mult_issue_ctl.sv
// Purpose : requester-side issue/return controller for the fixed-latency 64b multiplier wrapper.
// Latency : accept in cycle N -> o_mul_vld in N+1 -> result visible on o_rsp_vld in N+2+LAT.
// Backpressure: credit-based issue; o_req_rdy drops when all DEPTH credits are in use,
//               so the non-stallable multiplier pipe can never overflow the result FIFO.
//
// Ports (mult_issue_ctl):
//   ck, i_rst_n                        clock / async active-low reset
//   i_req_vld/i_req_a/i_req_b/i_req_htId/o_req_rdy   request channel (valid/ready)
//   o_mul_a/o_mul_b/o_mul_htId/o_mul_vld             to multiplier wrapper inputs
//   i_mul_res/i_mul_htId/i_mul_vld                   from multiplier wrapper outputs
//   o_rsp_vld/o_rsp_res/o_rsp_htId/i_rsp_rdy         response channel (show-ahead head)
//   o_credits                          free issue credits (debug/perf)
//   o_err                              sticky protocol error

// Purpose : generic show-ahead FIFO with full-and-pop-same-cycle pass-through.
// Latency : a push into an empty FIFO appears on o_vld/o_dat the next cycle.
// Backpressure: none upstream; a push while full without a pop is ignored (caller flags it).
module mult_issue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         ck,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic         o_vld,
    output logic [W-1:0] o_dat,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         empty;
    logic         pop_ok;
    logic         push_ok;

    always_comb begin
        empty  = (wr_ptr_q == rd_ptr_q);
        o_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok = i_pop && !empty;
        // When full, a simultaneous pop frees the head slot this edge, so the
        // write lands in the slot being vacated.
        push_ok  = i_push && (!o_full || pop_ok);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge ck or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge ck) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_dat;
        end
    end

    assign o_vld = !empty;
    assign o_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

module mult_issue_ctl #(
    parameter int DATA_W = 64,
    parameter int HTID_W = 9,
    parameter int LAT    = 18,
    parameter int DEPTH  = 32
) (
    input  logic                       ck,
    input  logic                       i_rst_n,
    input  logic                       i_req_vld,
    input  logic [DATA_W-1:0]          i_req_a,
    input  logic [DATA_W-1:0]          i_req_b,
    input  logic [HTID_W-1:0]          i_req_htId,
    output logic                       o_req_rdy,
    output logic [DATA_W-1:0]          o_mul_a,
    output logic [DATA_W-1:0]          o_mul_b,
    output logic [HTID_W-1:0]          o_mul_htId,
    output logic                       o_mul_vld,
    input  logic [DATA_W-1:0]          i_mul_res,
    input  logic [HTID_W-1:0]          i_mul_htId,
    input  logic                       i_mul_vld,
    output logic                       o_rsp_vld,
    output logic [DATA_W-1:0]          o_rsp_res,
    output logic [HTID_W-1:0]          o_rsp_htId,
    input  logic                       i_rsp_rdy,
    output logic [$clog2(DEPTH):0]     o_credits,
    output logic                       o_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    // A request is in flight for LAT+1 accept edges at most, and never more
    // than the credit pool allows.
    localparam int INFL_MAX = (LAT + 1 < DEPTH) ? (LAT + 1) : DEPTH;
    localparam int IW       = $clog2(INFL_MAX + 1);

    typedef struct packed {
        logic [HTID_W-1:0] htid;
        logic [DATA_W-1:0] res;
    } rsp_t;

    logic [CW-1:0]     credits_q, credits_d;
    logic              rdy_q, rdy_d;
    logic [IW-1:0]     inflight_q, inflight_d;
    logic              err_q, err_d;
    logic              mul_vld_q, mul_vld_d;
    logic [DATA_W-1:0] mul_a_q, mul_a_d;
    logic [DATA_W-1:0] mul_b_q, mul_b_d;
    logic [HTID_W-1:0] mul_htid_q, mul_htid_d;

    logic acc;
    logic pop;
    logic ret_orphan;
    logic ret_ok;
    logic overflow;
    logic fifo_vld;
    logic fifo_full;
    rsp_t push_dat;
    rsp_t head_dat;

    always_comb begin
        acc        = i_req_vld && rdy_q;
        pop        = fifo_vld && i_rsp_rdy;
        // A return with nothing outstanding is a protocol violation; it is dropped.
        ret_orphan = i_mul_vld && (inflight_q == '0);
        ret_ok     = i_mul_vld && !ret_orphan;
        overflow   = ret_ok && fifo_full && !pop;
        push_dat   = '{htid: i_mul_htId, res: i_mul_res};

        credits_d = credits_q;
        case ({acc, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
        // Registered so that ready has no path from i_req_vld and stays low in reset.
        rdy_d = (credits_d != '0);

        inflight_d = inflight_q;
        case ({acc, ret_ok})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase

        err_d = err_q || ret_orphan || overflow;

        mul_vld_d  = acc;
        mul_a_d    = acc ? i_req_a    : mul_a_q;
        mul_b_d    = acc ? i_req_b    : mul_b_q;
        mul_htid_d = acc ? i_req_htId : mul_htid_q;
    end

    always_ff @(posedge ck or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credits_q  <= CW'(DEPTH);
            rdy_q      <= 1'b0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            mul_vld_q  <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_htid_q <= '0;
        end else begin
            credits_q  <= credits_d;
            rdy_q      <= rdy_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            mul_vld_q  <= mul_vld_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_htid_q <= mul_htid_d;
        end
    end

    mult_issue_fifo #(
        .W     ($bits(rsp_t)),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .ck      (ck),
        .i_rst_n (i_rst_n),
        .i_push  (ret_ok),
        .i_dat   (push_dat),
        .i_pop   (pop),
        .o_vld   (fifo_vld),
        .o_dat   (head_dat),
        .o_full  (fifo_full)
    );

    assign o_req_rdy  = rdy_q;
    assign o_mul_vld  = mul_vld_q;
    assign o_mul_a    = mul_a_q;
    assign o_mul_b    = mul_b_q;
    assign o_mul_htId = mul_htid_q;
    assign o_rsp_vld  = fifo_vld;
    assign o_rsp_res  = head_dat.res;
    assign o_rsp_htId = head_dat.htid;
    assign o_credits  = credits_q;
    assign o_err      = err_q;
endmodule
